rf_scoreboard: RTL

- Tracks register-file writes that are in flight between decode issue and write-back retirement. Issue comes from the ID stage; retirement comes from the WB-stage `ws_reg` bus.
- Tells ID whether its rs/rt sources are still pending and must stall, with same-cycle bypass from the retiring WB write.
- Blocks issue when a destination's pending counter would saturate.
- Clears all pending state on a pipeline flush (exception/eret).

---
 rtl/rf_scoreboard_pkg.sv | 31 +++
 rtl/rf_scoreboard_sb_counter.sv | 45 ++++
 rtl/rf_scoreboard.sv | 100 ++++++++++
 3 files changed

// File: rtl/rf_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_scoreboard_pkg
// Description : Shared constants for the register-file scoreboard: GPR count,
//               pending-counter width and WB write bus field layout.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_scoreboard_pkg;

    localparam int c_NREG        = 32;
    localparam int c_CNT_W       = 2;
    localparam int c_REG_IDX_W   = 5;

    // WB write bus: {we[3:0], waddr[4:0], wdata[31:0]}
    localparam int c_WS_REG_WD   = 41;
    localparam int c_WS_WE_HI    = 40;
    localparam int c_WS_WE_LO    = 37;
    localparam int c_WS_WADDR_HI = 36;
    localparam int c_WS_WADDR_LO = 32;
    localparam int c_WS_WDATA_HI = 31;
    localparam int c_WS_WDATA_LO = 0;

    // A WB write retires a pending entry when any byte lane is enabled and
    // the target is not the hard-wired zero register.
    function automatic logic ws_retire(input logic [c_WS_REG_WD-1:0] ws);
        return (|ws[c_WS_WE_HI:c_WS_WE_LO]) &&
               (ws[c_WS_WADDR_HI:c_WS_WADDR_LO] != '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard_sb_counter.sv
`default_nettype none
// ============================================================================
// Module      : sb_counter
// Description : One per-register pending-write counter. Up/down, saturating
//               at both ends, with a synchronous clear that beats inc/dec.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] c_MAX  = '1;
    localparam logic [CNT_W-1:0] c_ZERO = '0;
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    // Count issues up and retirements down; simultaneous inc/dec cancel.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= c_ZERO;
        end else if (clr) begin
            r_count <= c_ZERO;
        end else if (inc && !dec && (r_count != c_MAX)) begin
            r_count <= r_count + c_ONE;
        end else if (dec && !inc && (r_count != c_ZERO)) begin
            r_count <= r_count - c_ONE;
        end
    end

    assign count = r_count;

    // Retiring a write that was never issued means the pipeline lost track.
    a_no_underflow : assert property (@(posedge clk) disable iff (reset)
        !(dec && !inc && !clr && (r_count == c_ZERO)));

endmodule
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : rf_scoreboard
// Description : Tracks GPR writes in flight between ID issue and WB retire.
//               Reports source hazards to ID (with WB bypass), blocks issue
//               when a destination counter is saturated, clears on flush.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_scoreboard
    import rf_scoreboard_pkg::*;
#(
    parameter int NREG  = c_NREG,
    parameter int CNT_W = c_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ds_issue_valid,
    input  logic                   ds_issue_we,
    input  logic [c_REG_IDX_W-1:0] ds_issue_dest,
    output logic                   ds_issue_allow,
    input  logic [c_REG_IDX_W-1:0] ds_rs,
    input  logic                   ds_rs_en,
    input  logic [c_REG_IDX_W-1:0] ds_rt,
    input  logic                   ds_rt_en,
    output logic                   ds_rs_busy,
    output logic                   ds_rt_busy,
    output logic                   ds_stall,
    input  logic [c_WS_REG_WD-1:0] ws_reg,
    input  logic                   flush,
    output logic                   busy_any
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]       w_cnt [NREG];
    logic                   w_ret;
    logic [c_REG_IDX_W-1:0] w_ret_dest;
    logic                   w_iss;
    logic                   w_unused_wdata;

    assign w_ret          = ws_retire(ws_reg);
    assign w_ret_dest     = ws_reg[c_WS_WADDR_HI:c_WS_WADDR_LO];
    assign w_unused_wdata = &{1'b0, ws_reg[c_WS_WDATA_HI:c_WS_WDATA_LO]};

    // Issue is dropped in a flush cycle; the clear wins anyway, but keeping
    // it out of inc avoids a spurious inc/dec cancellation on that edge.
    assign w_iss = ds_issue_valid && ds_issue_we && ds_issue_allow &&
                   (ds_issue_dest != '0) && !flush;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign w_cnt[gi] = '0;
            end else begin : g_ctr
                sb_counter #(
                    .CNT_W (CNT_W)
                ) u_cnt (
                    .clk   (clk),
                    .reset (reset),
                    .inc   (w_iss && (ds_issue_dest == c_REG_IDX_W'(gi))),
                    .dec   (w_ret && (w_ret_dest == c_REG_IDX_W'(gi))),
                    .clr   (flush),
                    .count (w_cnt[gi])
                );
            end
        end
    endgenerate

    // A saturated destination may still issue if one of its writes retires now.
    always_comb begin
        ds_issue_allow = 1'b1;
        if (ds_issue_we && (ds_issue_dest != '0) &&
            (w_cnt[ds_issue_dest] == c_CNT_MAX) &&
            !(w_ret && (w_ret_dest == ds_issue_dest))) begin
            ds_issue_allow = 1'b0;
        end
    end

    // Source hazards; the last pending write retiring this cycle is forwarded.
    always_comb begin
        ds_rs_busy = ds_rs_en && (ds_rs != '0) && (w_cnt[ds_rs] != '0) &&
                     !(w_ret && (w_ret_dest == ds_rs) && (w_cnt[ds_rs] == c_CNT_ONE));
        ds_rt_busy = ds_rt_en && (ds_rt != '0) && (w_cnt[ds_rt] != '0) &&
                     !(w_ret && (w_ret_dest == ds_rt) && (w_cnt[ds_rt] == c_CNT_ONE));
        ds_stall   = ds_rs_busy || ds_rt_busy || (ds_issue_valid && !ds_issue_allow);
    end

    // Any register with an outstanding write.
    always_comb begin
        busy_any = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            if (w_cnt[i] != '0) begin
                busy_any = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
